// File: rtl/axi_rd_initiator.sv
// rtl/axi_rd_initiator.sv - AXI4 read-channel initiator, one INCR burst outstanding at a time
//
// Optional build macro: AXI_RD_CHECK_EN
//   When defined, each accepted R beat is checked for a wrong rid and for rlast
//   placement against the latched length. Any violation sets the sticky proto_err.
//   The burst also ends after the last expected beat if rlast never arrives.
//   When undefined, proto_err is tied 0 and only rlast ends a burst.
//
// Ports:
//   clk, rst (async, active-low)
//   front-end request : req_valid/req_ready, req_addr, req_len, req_size, req_id
//   front-end response: resp_valid/resp_ready, resp_data, resp_last, resp_err
//   status            : busy, proto_err
//   AXI AR channel    : arvalid/arready, araddr, arid, arlen, arsize, arburst
//   AXI R channel     : rvalid/rready, rdata, rresp, rlast, rid

module axi_rd_initiator #(
    parameter int ID_W   = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_len,
    input  logic [2:0]        req_size,
    input  logic [ID_W-1:0]   req_id,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic              resp_err,

    output logic              busy,
    output logic              proto_err,

    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [ID_W-1:0]   arid,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,

    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic [ID_W-1:0]   rid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] beat_cnt;
    logic       in_r;
    logic       beat_fire;
    logic       burst_done;

    assign in_r      = (state == S_R);
    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign arburst   = 2'b01;

    // R channel is a straight pass-through to the requester while in R;
    // outside R nothing is accepted so late beats from an abandoned burst are dropped.
    assign rready     = in_r & resp_ready;
    assign resp_valid = in_r & rvalid;
    assign resp_data  = rdata;
    assign resp_last  = rlast;
    assign resp_err   = (rresp != 2'b00);

    assign beat_fire = rvalid & rready;

`ifdef AXI_RD_CHECK_EN
    logic beat_bad;

    // beat_cnt holds the index of the beat being accepted, so it equals arlen
    // exactly on the final expected beat.
    assign beat_bad   = (rid != arid) |
                        (rlast & (beat_cnt != arlen)) |
                        (~rlast & (beat_cnt == arlen));
    assign burst_done = rlast | (beat_cnt == arlen);
`else
    logic unused_sig;

    assign unused_sig = ^{rid, beat_cnt};
    assign burst_done = rlast;
    assign proto_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            arvalid  <= 1'b0;
            araddr   <= '0;
            arid     <= '0;
            arlen    <= '0;
            arsize   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        araddr  <= req_addr;
                        arid    <= req_id;
                        arlen   <= req_len;
                        arsize  <= req_size;
                        arvalid <= 1'b1;
                        state   <= S_AR;
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        state   <= S_R;
                    end
                end
                S_R: begin
                    if (beat_fire) begin
                        if (burst_done) begin
                            beat_cnt <= '0;
                            state    <= S_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    arvalid <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXI_RD_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            proto_err <= 1'b0;
        end else if (in_r && beat_fire && beat_bad) begin
            proto_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_rd_initiator.sv
// tb/tb_axi_rd_initiator.sv - directed self-checking bench for axi_rd_initiator

module tb_axi_rd_initiator;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [2:0]  req_size;
    logic [3:0]  req_id;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_last;
    logic        resp_err;
    logic        busy;
    logic        proto_err;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    int tests;
    int failed;
    int beat;

`ifdef AXI_RD_CHECK_EN
    localparam logic EXP_PERR = 1'b1;
`else
    localparam logic EXP_PERR = 1'b0;
`endif

    axi_rd_initiator #(.ID_W(4), .DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_len(req_len), .req_size(req_size), .req_id(req_id),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_last(resp_last), .resp_err(resp_err),
        .busy(busy), .proto_err(proto_err),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 2ns past the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present a request for one cycle; returns with arvalid expected high.
    task automatic send_req(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        req_size  = 3'd2;
        req_id    = id;
        tick();
        req_valid = 1'b0;
    endtask

    // Drive one R beat with resp_ready=1 and let it be accepted.
    task automatic r_beat(input logic [31:0] d, input logic [1:0] rs, input logic last, input logic [3:0] i);
        rvalid     = 1'b1;
        rdata      = d;
        rresp      = rs;
        rlast      = last;
        rid        = i;
        resp_ready = 1'b1;
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    initial begin
        tests = 0; failed = 0;
        rst = 1'b0;
        req_valid = 0; req_addr = 0; req_len = 0; req_size = 0; req_id = 0;
        resp_ready = 0; arready = 0;
        rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;

        // Reset state
        #12;
        check("rst_arvalid", {31'd0, arvalid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_araddr", araddr, 32'd0);
        check("rst_arlen", {24'd0, arlen}, 32'd0);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        check("rst_rready", {31'd0, rready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Single beat, arready held high
        arready = 1'b1;
        send_req(32'h0200_BFF8, 8'd0, 4'd3);
        check("t1_arvalid", {31'd0, arvalid}, 32'd1);
        check("t1_araddr", araddr, 32'h0200_BFF8);
        check("t1_arlen", {24'd0, arlen}, 32'd0);
        check("t1_arid", {28'd0, arid}, 32'd3);
        check("t1_arsize", {29'd0, arsize}, 32'd2);
        check("t1_arburst", {30'd0, arburst}, 32'd1);
        check("t1_req_ready_ar", {31'd0, req_ready}, 32'd0);
        check("t1_busy_ar", {31'd0, busy}, 32'd1);
        rvalid = 1'b1; rdata = 32'h1234_5678; rlast = 1'b1; rresp = 2'b00; rid = 4'd3;
        resp_ready = 1'b1;
        #1;
        check("t1_rvalid_in_ar", {31'd0, rready}, 32'd0);
        check("t1_resp_valid_in_ar", {31'd0, resp_valid}, 32'd0);
        tick();
        check("t1_arvalid_drop", {31'd0, arvalid}, 32'd0);
        check("t1_resp_valid", {31'd0, resp_valid}, 32'd1);
        check("t1_resp_data", resp_data, 32'h1234_5678);
        check("t1_resp_last", {31'd0, resp_last}, 32'd1);
        check("t1_resp_err", {31'd0, resp_err}, 32'd0);
        check("t1_rready", {31'd0, rready}, 32'd1);
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        check("t1_req_ready_done", {31'd0, req_ready}, 32'd1);
        check("t1_busy_done", {31'd0, busy}, 32'd0);
        check("t1_proto_err", {31'd0, proto_err}, 32'd0);

        // AR stall for 5 cycles
        arready = 1'b0;
        send_req(32'h8000_0040, 8'd0, 4'd1);
        for (int i = 0; i < 5; i++) begin
            check("t2_arvalid_stall", {31'd0, arvalid}, 32'd1);
            check("t2_araddr_stall", araddr, 32'h8000_0040);
            check("t2_req_ready_stall", {31'd0, req_ready}, 32'd0);
            tick();
        end
        arready = 1'b1;
        check("t2_arvalid_hs", {31'd0, arvalid}, 32'd1);
        check("t2_araddr_hs", araddr, 32'h8000_0040);
        tick();
        check("t2_arvalid_after", {31'd0, arvalid}, 32'd0);
        r_beat(32'h5555_AAAA, 2'b00, 1'b1, 4'd1);
        check("t2_idle", {31'd0, req_ready}, 32'd1);

        // len=3 burst with resp_ready toggling
        send_req(32'h0000_1000, 8'd3, 4'd2);
        tick();
        beat = 0;
        for (int cyc = 0; cyc < 7; cyc++) begin
            resp_ready = (cyc % 2 == 0);
            rvalid = 1'b1;
            rdata  = 32'hA0 + beat;
            rlast  = (beat == 3);
            rid    = 4'd2;
            #1;
            check("t3_rready_mirror", {31'd0, rready}, {31'd0, resp_ready});
            check("t3_resp_data", resp_data, 32'hA0 + beat);
            check("t3_busy", {31'd0, busy}, 32'd1);
            if (resp_ready) beat++;
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0;
        check("t3_beats", beat, 32'd4);
        check("t3_idle", {31'd0, busy}, 32'd0);

        // Error response on beat 1 of len=1
        send_req(32'h0000_2000, 8'd1, 4'd4);
        tick();
        rvalid = 1'b1; rdata = 32'hE0; rresp = 2'b00; rlast = 1'b0; rid = 4'd4; resp_ready = 1'b1;
        #1;
        check("t4_err_b0", {31'd0, resp_err}, 32'd0);
        tick();
        rdata = 32'hE1; rresp = 2'b10; rlast = 1'b1;
        #1;
        check("t4_err_b1", {31'd0, resp_err}, 32'd1);
        check("t4_valid_b1", {31'd0, resp_valid}, 32'd1);
        check("t4_busy_b1", {31'd0, busy}, 32'd1);
        tick();
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        check("t4_idle", {31'd0, req_ready}, 32'd1);

        // Async reset mid-burst
        send_req(32'h0000_3000, 8'd3, 4'd5);
        tick();
        r_beat(32'hB0, 2'b00, 1'b0, 4'd5);
        rvalid = 1'b1; rdata = 32'hB1;
        #1;
        rst = 1'b0;
        #1;
        check("t5_rready", {31'd0, rready}, 32'd0);
        check("t5_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("t5_arvalid", {31'd0, arvalid}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        rvalid = 1'b0;
        tick();
        send_req(32'h0000_4000, 8'd0, 4'd6);
        check("t5_new_araddr", araddr, 32'h0000_4000);
        tick();
        r_beat(32'hC0, 2'b00, 1'b1, 4'd6);
        check("t5_new_done", {31'd0, busy}, 32'd0);

        // Protocol checks: wrong rid
        send_req(32'h0000_5000, 8'd0, 4'd3);
        tick();
        r_beat(32'hD0, 2'b00, 1'b1, 4'd5);
        check("t6_rid_perr", {31'd0, proto_err}, {31'd0, EXP_PERR});
        send_req(32'h0000_5004, 8'd0, 4'd3);
        tick();
        r_beat(32'hD1, 2'b00, 1'b1, 4'd3);
        check("t6_perr_sticky", {31'd0, proto_err}, {31'd0, EXP_PERR});

        // Protocol checks: early rlast on len=2
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_perr_cleared", {31'd0, proto_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        send_req(32'h0000_6000, 8'd2, 4'd7);
        tick();
        r_beat(32'hF0, 2'b00, 1'b0, 4'd7);
        check("t6_perr_b0", {31'd0, proto_err}, 32'd0);
        r_beat(32'hF1, 2'b00, 1'b1, 4'd7);
        check("t6_early_last_perr", {31'd0, proto_err}, {31'd0, EXP_PERR});
        check("t6_early_last_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
